// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked ALU execution unit with single-cycle logic/arith
// ops and an iterative LSB-first shift-add multiplier.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_ctl,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_NOR = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] alu_res_c;
  logic [WIDTH-1:0] acc_next_c;

  // Single-cycle result for the request currently presented
  always_comb begin
    alu_res_c = '0;
    case (req_ctl)
      OP_AND:  alu_res_c = req_a & req_b;
      OP_OR:   alu_res_c = req_a | req_b;
      OP_ADD:  alu_res_c = req_a + req_b;
      OP_SUB:  alu_res_c = req_a - req_b;
      OP_SLT:  alu_res_c = WIDTH'($signed(req_a) < $signed(req_b));
      OP_NOR:  alu_res_c = ~(req_a | req_b);
      default: alu_res_c = '0;
    endcase
  end

  // One shift-add multiply step
  always_comb begin
    acc_next_c = acc;
    if (b_q[0]) acc_next_c = acc + a_q;
  end

  // Control FSM, operand/accumulator datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc         <= '0;
      cnt         <= '0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_ctl == OP_MUL) begin
              a_q   <= req_a;
              b_q   <= req_b;
              acc   <= '0;
              cnt   <= '0;
              state <= ST_MUL;
            end else begin
              resp_result <= alu_res_c;
              resp_zero   <= (alu_res_c == '0);
              resp_valid  <= 1'b1;
              state       <= ST_DONE;
            end
          end
        end
        ST_MUL: begin
          acc <= acc_next_c;
          a_q <= a_q << 1;
          b_q <= b_q >> 1;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            resp_result <= acc_next_c;
            resp_zero   <= (acc_next_c == '0);
            resp_valid  <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state      <= ST_IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit.
module tb_alu_exec_unit;

  localparam int unsigned WIDTH = 64;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_ctl;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_result;
  logic             resp_zero;
  logic             busy;

  int errors = 0;
  int checks = 0;

  alu_exec_unit #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_ctl     (req_ctl),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_zero   (resp_zero),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, wait for the response, check latency/result/zero,
  // then consume it (resp_ready held high) and check the return to idle.
  task automatic run_op(input string tag, input logic [3:0] ctl,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] exp_res, input logic exp_zero,
                        input int exp_lat);
    int lat;
    int guard;
    guard = 0;
    while (!req_ready && guard < 200) begin
      tick();
      guard++;
    end
    check({tag, "_ready"}, WIDTH'(req_ready), WIDTH'(1));
    req_valid  = 1'b1;
    req_ctl    = ctl;
    req_a      = a;
    req_b      = b;
    resp_ready = 1'b1;
    tick();  // accept edge E0
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_ctl   = 4'd0;
    lat = 0;
    while (!resp_valid && lat < 200) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, WIDTH'(lat), WIDTH'(exp_lat));
    check({tag, "_res"}, resp_result, exp_res);
    check({tag, "_zero"}, WIDTH'(resp_zero), WIDTH'(exp_zero));
    tick();  // consumed at this edge
    check({tag, "_vld_drop"}, WIDTH'(resp_valid), WIDTH'(0));
    check({tag, "_rdy_back"}, WIDTH'(req_ready), WIDTH'(1));
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_ctl    = 4'd0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    #12;
    check("rst_req_ready", WIDTH'(req_ready), WIDTH'(1));
    check("rst_resp_valid", WIDTH'(resp_valid), WIDTH'(0));
    check("rst_result", resp_result, '0);
    check("rst_zero", WIDTH'(resp_zero), WIDTH'(0));
    check("rst_busy", WIDTH'(busy), WIDTH'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic ops with A=5, B=12
    run_op("and", 4'd0, 64'd5, 64'd12, 64'd4, 1'b0, 0);
    run_op("or", 4'd1, 64'd5, 64'd12, 64'd13, 1'b0, 0);
    run_op("add", 4'd2, 64'd5, 64'd12, 64'd17, 1'b0, 0);
    run_op("sub", 4'd6, 64'd5, 64'd12, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 0);
    run_op("slt", 4'd7, 64'd5, 64'd12, 64'd1, 1'b0, 0);
    run_op("nor", 4'd12, 64'd5, 64'd12, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0, 0);

    // Zero flag, signed compare edge cases, undefined op code
    run_op("sub_eq", 4'd6, 64'h1234, 64'h1234, 64'd0, 1'b1, 0);
    run_op("slt_m1_1", 4'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1'b0, 0);
    run_op("slt_1_m1", 4'd7, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 0);
    run_op("undef", 4'd5, 64'd5, 64'd12, 64'd0, 1'b1, 0);

    // Multiply (operands are zeroed right after accept inside run_op)
    run_op("mul_5x12", 4'd3, 64'd5, 64'd12, 64'd60, 1'b0, 64);
    run_op("mul_m1x2", 4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 64);
    run_op("mul_x0", 4'd3, 64'd7, 64'd0, 64'd0, 1'b1, 64);

    // Backpressure: hold result for 10 cycles while a new request is offered
    req_valid  = 1'b1;
    req_ctl    = 4'd2;
    req_a      = 64'd5;
    req_b      = 64'd12;
    resp_ready = 1'b0;
    tick();
    req_ctl = 4'd0;
    req_a   = 64'd0;
    req_b   = 64'd0;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", WIDTH'(resp_valid), WIDTH'(1));
      check("bp_result", resp_result, 64'd17);
      check("bp_req_ready", WIDTH'(req_ready), WIDTH'(0));
      check("bp_busy", WIDTH'(busy), WIDTH'(1));
      tick();
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    tick();
    check("bp_consumed", WIDTH'(resp_valid), WIDTH'(0));
    check("bp_ready_back", WIDTH'(req_ready), WIDTH'(1));
    check("bp_idle_busy", WIDTH'(busy), WIDTH'(0));
    tick();
    check("bp_no_stale", WIDTH'(resp_valid), WIDTH'(0));

    // Asynchronous reset in the middle of a multiply
    req_valid = 1'b1;
    req_ctl   = 4'd3;
    req_a     = 64'd5;
    req_b     = 64'd12;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    check("mrst_busy_before", WIDTH'(busy), WIDTH'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_req_ready", WIDTH'(req_ready), WIDTH'(1));
    check("mrst_resp_valid", WIDTH'(resp_valid), WIDTH'(0));
    check("mrst_result", resp_result, '0);
    check("mrst_zero", WIDTH'(resp_zero), WIDTH'(0));
    check("mrst_busy", WIDTH'(busy), WIDTH'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (i % 10 == 0) check("mrst_no_resp", WIDTH'(resp_valid), WIDTH'(0));
    end
    check("mrst_ready_after", WIDTH'(req_ready), WIDTH'(1));
    run_op("add_after_rst", 4'd2, 64'd5, 64'd12, 64'd17, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
